// File: rtl/phase_ctrl_if.sv
// Bundle between the phase controller and its decoder, ALU and shared memory.
// The master modport is the controller's side, and the slave modport is the environment's side.
interface phase_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic             halt_req;
  logic             mem_op;
  logic             mem_wr;
  logic             reg_wr;
  logic             br_taken;
  logic             mem_ack;
  logic [4:0]       phase;
  logic             mem_req;
  logic             mem_sel;
  logic             mem_we;
  logic             ir_we;
  logic             pc_we;
  logic             pc_sel;
  logic             rf_we;
  logic             halted;
  logic             err;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  run, halt_req, mem_op, mem_wr, reg_wr, br_taken, mem_ack,
    output phase, mem_req, mem_sel, mem_we, ir_we, pc_we, pc_sel, rf_we,
           halted, err, instr_cnt
  );

  modport slave (
    output run, halt_req, mem_op, mem_wr, reg_wr, br_taken, mem_ack,
    input  phase, mem_req, mem_sel, mem_we, ir_we, pc_we, pc_sel, rf_we,
           halted, err, instr_cnt
  );
endinterface

// File: rtl/phase_ctrl.sv
// Multi-cycle instruction phase sequencer (fetch/read/execute/memory/writeback)
// sharing one memory port, with a memory-ack timeout and a retired-instruction counter.
//
// state  | meaning
// IDLE   | waiting for run
// F      | instruction fetch, waiting for mem_ack
// R      | register read / decode, one cycle
// X      | execute, latches branch outcome, one cycle
// M      | data access, waiting for mem_ack
// W      | writeback and PC update, one cycle
// HALT   | stopped on HLT until reset
// ERR    | memory timeout until reset
module phase_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input logic          clk_i,
  input logic          rst_i,
  phase_ctrl_if.master bus_if
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_F, S_R, S_X, S_M, S_W, S_HALT, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic              br_q, br_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [4:0] phase_o;
  logic       mem_req_o, mem_sel_o, mem_we_o, ir_we_o;
  logic       pc_we_o, pc_sel_o, rf_we_o, halted_o, err_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      br_q    <= 1'b0;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      br_q    <= br_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    br_d      = br_q;
    wait_d    = wait_q;
    cnt_d     = cnt_q;
    phase_o   = 5'b00000;
    mem_req_o = 1'b0;
    mem_sel_o = 1'b0;
    mem_we_o  = 1'b0;
    ir_we_o   = 1'b0;
    pc_we_o   = 1'b0;
    pc_sel_o  = 1'b0;
    rf_we_o   = 1'b0;
    halted_o  = 1'b0;
    err_o     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus_if.run) begin
          state_d = S_F;
          wait_d  = '0;
        end
      end
      S_F: begin
        phase_o   = 5'b00001;
        mem_req_o = 1'b1;
        // An ack arriving on the last allowed cycle still beats the timeout.
        if (bus_if.mem_ack) begin
          ir_we_o = 1'b1;
          state_d = S_R;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_R: begin
        phase_o = 5'b00010;
        state_d = bus_if.halt_req ? S_HALT : S_X;
      end
      S_X: begin
        phase_o = 5'b00100;
        br_d    = bus_if.br_taken;
        if (bus_if.mem_op) begin
          state_d = S_M;
          wait_d  = '0;
        end else begin
          state_d = S_W;
        end
      end
      S_M: begin
        phase_o   = 5'b01000;
        mem_req_o = 1'b1;
        mem_sel_o = 1'b1;
        mem_we_o  = bus_if.mem_wr;
        if (bus_if.mem_ack) begin
          state_d = S_W;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_W: begin
        phase_o  = 5'b10000;
        pc_we_o  = 1'b1;
        pc_sel_o = br_q;
        rf_we_o  = bus_if.reg_wr;
        cnt_d    = cnt_q + 1'b1;
        if (bus_if.run) begin
          state_d = S_F;
          wait_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALT:  halted_o = 1'b1;
      S_ERR:   err_o    = 1'b1;
      default: state_d  = S_IDLE;
    endcase
  end

  assign bus_if.phase     = phase_o;
  assign bus_if.mem_req   = mem_req_o;
  assign bus_if.mem_sel   = mem_sel_o;
  assign bus_if.mem_we    = mem_we_o;
  assign bus_if.ir_we     = ir_we_o;
  assign bus_if.pc_we     = pc_we_o;
  assign bus_if.pc_sel    = pc_sel_o;
  assign bus_if.rf_we     = rf_we_o;
  assign bus_if.halted    = halted_o;
  assign bus_if.err       = err_o;
  assign bus_if.instr_cnt = cnt_q;
endmodule

// File: tb/tb_phase_ctrl.sv
// Instruction-level bench for phase_ctrl: each instruction is described by its fields
// and ack delays, and the expected per-cycle outputs are derived from that description.
module tb_phase_ctrl;
  localparam int TO = 15;
  localparam int CW = 4;
  localparam logic [13:0] ZERO = 14'h0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phase_ctrl_if #(.CNT_W(CW)) bus_if ();
  phase_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_if(bus_if)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int exp_cnt = 0;   // retired instructions modulo 2^CW
  bit idle  = 1'b1;  // model: controller sits in IDLE
  bit stuck = 1'b0;  // model: controller in HALT or ERR

  function automatic logic [13:0] ev(input logic [4:0] ph, input logic req, sel, we, ir,
                                     pcwe, pcsel, rf, hlt, er);
    return {ph, req, sel, we, ir, pcwe, pcsel, rf, hlt, er};
  endfunction

  task automatic junk();
    bus_if.run      = 1'($urandom);
    bus_if.halt_req = 1'($urandom);
    bus_if.mem_op   = 1'($urandom);
    bus_if.mem_wr   = 1'($urandom);
    bus_if.reg_wr   = 1'($urandom);
    bus_if.br_taken = 1'($urandom);
    bus_if.mem_ack  = 1'($urandom);
  endtask

  // Entered at a falling edge with inputs already driven; leaves at the next falling edge.
  task automatic step(input logic [13:0] exp, input string tag);
    logic [13:0] obs;
    #1;
    obs = {bus_if.phase, bus_if.mem_req, bus_if.mem_sel, bus_if.mem_we, bus_if.ir_we,
           bus_if.pc_we, bus_if.pc_sel, bus_if.rf_we, bus_if.halted, bus_if.err};
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: outputs got %h expected %h", tag, obs, exp);
    end
    n_chk++;
    assert (bus_if.instr_cnt === CW'(exp_cnt)) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s_cnt: instr_cnt got %0d expected %0d", tag, bus_if.instr_cnt, exp_cnt);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic err_tail();
    for (int i = 0; i < 3; i++) begin
      junk();
      step(ev(5'b0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "err");
    end
    stuck = 1'b1;
  endtask

  task automatic do_reset();
    junk();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    idle = 1'b1;
    stuck = 1'b0;
    junk();
    bus_if.run = 1'b0;
    step(ZERO, "post_rst");
  endtask

  // fd/md: ack delay in F/M (>= TO means no ack, so timeout); rst_m: M cycle to reset in, or -1.
  task automatic do_instr(input bit op, wr, rw, br, hlt, input int fd, md,
                          input bit run_after, input int rst_m);
    if (idle) begin
      for (int i = 0; i < int'($urandom_range(2)); i++) begin
        junk();
        bus_if.run = 1'b0;
        step(ZERO, "idle_wait");
      end
      junk();
      bus_if.run = 1'b1;
      step(ZERO, "idle_go");
    end
    idle = 1'b0;
    for (int i = 0; i <= fd && i < TO; i++) begin
      junk();
      bus_if.mem_ack = (i == fd);
      step(ev(5'b00001, 1, 0, 0, (i == fd), 0, 0, 0, 0, 0), "fetch");
    end
    if (fd >= TO) begin
      err_tail();
      return;
    end
    junk();
    bus_if.halt_req = hlt;
    step(ev(5'b00010, 0, 0, 0, 0, 0, 0, 0, 0, 0), "read");
    if (hlt) begin
      for (int i = 0; i < 4; i++) begin
        junk();
        step(ev(5'b0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "halt");
      end
      stuck = 1'b1;
      return;
    end
    junk();
    bus_if.mem_op   = op;
    bus_if.br_taken = br;
    step(ev(5'b00100, 0, 0, 0, 0, 0, 0, 0, 0, 0), "exec");
    if (op) begin
      for (int i = 0; i <= md && i < TO; i++) begin
        junk();
        bus_if.mem_wr  = wr;
        bus_if.mem_ack = (i == md);
        if (i == rst_m) begin
          bus_if.mem_ack = 1'b0;
          rst = 1'b1;
          step(ev(5'b01000, 1, 1, wr, 0, 0, 0, 0, 0, 0), "mem_rst");
          rst = 1'b0;
          exp_cnt = 0;
          idle = 1'b1;
          junk();
          bus_if.run = 1'b0;
          step(ZERO, "after_mem_rst");
          return;
        end
        step(ev(5'b01000, 1, 1, wr, 0, 0, 0, 0, 0, 0), "mem");
      end
      if (md >= TO) begin
        err_tail();
        return;
      end
    end
    junk();
    bus_if.reg_wr = rw;
    bus_if.run    = run_after;
    step(ev(5'b10000, 0, 0, 0, 0, 1, br, rw, 0, 0), "wb");
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    idle = !run_after;
  endtask

  initial begin
    rst = 1'b1;
    junk();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    junk();
    bus_if.run = 1'b0;
    step(ZERO, "reset");

    // Back-to-back ALU instructions with immediate acks.
    for (int i = 0; i < 3; i++) do_instr(0, 0, 1, 0, 0, 0, 0, 1, -1);
    // Load then store, ack three cycles late.
    do_instr(1, 0, 1, 0, 0, 0, 3, 1, -1);
    do_instr(1, 1, 0, 0, 0, 0, 3, 1, -1);
    // Taken branch followed by not-taken.
    do_instr(0, 0, 0, 1, 0, 0, 0, 1, -1);
    do_instr(0, 0, 1, 0, 0, 1, 0, 0, -1);
    // Halt.
    do_instr(0, 0, 0, 0, 1, 0, 0, 1, -1);
    do_reset();
    // Ack on the last allowed cycle, then timeouts in F and in M.
    do_instr(0, 0, 1, 0, 0, TO - 1, 0, 1, -1);
    do_instr(1, 0, 1, 1, 0, 0, TO - 1, 1, -1);
    do_instr(0, 0, 1, 0, 0, TO, 0, 1, -1);
    do_reset();
    do_instr(1, 1, 1, 0, 0, 2, TO, 1, -1);
    do_reset();
    // Reset in the middle of a memory wait.
    do_instr(0, 0, 1, 0, 0, 0, 0, 1, -1);
    do_instr(1, 0, 1, 0, 0, 0, 5, 1, 2);
    // Counter wrap.
    for (int i = 0; i < 17; i++) do_instr(0, 0, 1, 0, 0, 0, 0, 1, -1);

    // Randomized instruction stream.
    for (int n = 0; n < 80; n++) begin
      bit op, wr, rw, br, hlt, ra;
      int fd, md;
      op  = 1'($urandom);
      wr  = 1'($urandom);
      rw  = 1'($urandom);
      br  = 1'($urandom);
      hlt = ($urandom_range(15) == 0);
      ra  = ($urandom_range(3) != 0);
      fd  = ($urandom_range(3) == 0) ? int'($urandom_range(TO - 1)) : int'($urandom_range(1));
      md  = int'($urandom_range(4));
      if ($urandom_range(40) == 0) fd = TO;
      do_instr(op, wr, rw, br, hlt, fd, md, ra, -1);
      if (stuck) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
